// File: rtl/out_port_arbiter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | out_port_arbiter_pkg                                                      |
// | Shared router widths and helpers for the per-output-port switch allocator.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package out_port_arbiter_pkg;

  localparam int PORT    = 4;
  localparam int VCHW    = 0;
  localparam int NVC_DEF = 2;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [PORT:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i <= PORT; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_arbiter_rr.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_arbiter5                                                               |
// | Combinational 5-way round-robin picker: first eligible after ptr_i.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rr_arbiter5 (
  input  logic [4:0] elig_i,
  input  logic [2:0] ptr_i,
  output logic [4:0] win_o
);

  logic       found;
  logic [3:0] idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 5; k++) begin
      idx = {1'b0, ptr_i} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && elig_i[idx[2:0]]) begin
        win_o[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/out_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | out_port_arbiter                                                          |
// | Packet-locked round-robin switch allocator with per-VC credit gating.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int NVC          = NVC_DEF,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PORT:0]   ireq,
  input  logic [PORT:0]   ihead,
  input  logic [PORT:0]   itail,
  input  logic [VCHW:0]   ivch_0,
  input  logic [VCHW:0]   ivch_1,
  input  logic [VCHW:0]   ivch_2,
  input  logic [VCHW:0]   ivch_3,
  input  logic [VCHW:0]   ivch_4,
  input  logic            icredit,
  input  logic [VCHW:0]   icredit_vch,
  output logic [PORT:0]   sel,
  output logic [PORT:0]   ogrant,
  output logic [VCHW:0]   olock_vch,
  output logic            ocred_err
);

  localparam int            CW        = cred_w(CREDIT_DEPTH);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);
  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_LOCKED  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PORT:0] sel_q, sel_d;
  logic [VCHW:0] lock_vch_q, lock_vch_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] credit_q [NVC];
  logic          cred_err_q, cred_err_d;

  logic [VCHW:0]  vch_w [PORT+1];
  logic [PORT:0]  elig;
  logic [PORT:0]  win;
  logic [VCHW:0]  win_vch;
  logic           lock_has_cred;
  logic           grant_any;
  logic           grant_tail;
  logic [NVC-1:0] dec_vec;
  logic [NVC-1:0] inc_vec;

  assign vch_w[0] = ivch_0;
  assign vch_w[1] = ivch_1;
  assign vch_w[2] = ivch_2;
  assign vch_w[3] = ivch_3;
  assign vch_w[4] = ivch_4;

  // Only head flits with downstream room may start a packet.
  for (genvar i = 0; i <= PORT; i++) begin : g_elig
    assign elig[i] = (state_q == S_IDLE) & ireq[i] & ihead[i] & (credit_q[vch_w[i]] != '0);
  end

  rr_arbiter5 u_rr (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .win_o  (win)
  );

  always_comb begin
    win_vch = '0;
    for (int i = 0; i <= PORT; i++) begin
      if (win[i]) win_vch = win_vch | vch_w[i];
    end
  end

  assign lock_has_cred = (credit_q[lock_vch_q] != '0);
  assign ogrant        = (state_q == S_LOCKED) ? (sel_q & ireq & {(PORT+1){lock_has_cred}}) : '0;
  assign grant_any     = |ogrant;
  assign grant_tail    = |(ogrant & itail);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    lock_vch_d = lock_vch_q;
    rr_ptr_d   = rr_ptr_q;
    if (state_q == S_IDLE) begin
      if (|win) begin
        state_d    = S_LOCKED;
        sel_d      = win;
        lock_vch_d = win_vch;
      end
    end else if (grant_tail) begin
      state_d  = S_IDLE;
      sel_d    = '0;
      rr_ptr_d = onehot_to_idx(sel_q);
    end
  end

  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      dec_vec[v] = grant_any & (lock_vch_q == (VCHW+1)'(v));
      inc_vec[v] = icredit & (icredit_vch == (VCHW+1)'(v));
    end
  end

  // A same-cycle consume cancels the return, so that case is never an overflow.
  assign cred_err_d = icredit & (credit_q[icredit_vch] == CRED_FULL) & ~dec_vec[icredit_vch];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      lock_vch_q <= '0;
      rr_ptr_q   <= 3'd4;
      cred_err_q <= 1'b0;
      for (int v = 0; v < NVC; v++) credit_q[v] <= CRED_FULL;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      lock_vch_q <= lock_vch_d;
      rr_ptr_q   <= rr_ptr_d;
      cred_err_q <= cred_err_d;
      for (int v = 0; v < NVC; v++) begin
        if (dec_vec[v] && !inc_vec[v]) begin
          credit_q[v] <= credit_q[v] - CW'(1);
        end else if (inc_vec[v] && !dec_vec[v] && credit_q[v] != CRED_FULL) begin
          credit_q[v] <= credit_q[v] + CW'(1);
        end
      end
    end
  end

  assign sel       = sel_q;
  assign olock_vch = lock_vch_q;
  assign ocred_err = cred_err_q;

endmodule
`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_out_port_arbiter                                                       |
// | Directed test-plan scenarios plus random traffic against a packet model.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_out_port_arbiter;
  import out_port_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PORT:0]      ireq, ihead, itail;
  logic [PORT:0][VCHW:0] ivch;
  logic               icredit;
  logic [VCHW:0]      icredit_vch;
  logic [PORT:0]      sel, ogrant;
  logic [VCHW:0]      olock_vch;
  logic               ocred_err;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level reference state
  int m_locked = 0;
  int m_owner  = 0;
  int m_lvc    = 0;
  int m_rr     = 4;
  int m_err    = 0;
  int m_cr [2] = '{DEPTH, DEPTH};

  out_port_arbiter #(.NVC(2), .CREDIT_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ireq        (ireq),
    .ihead       (ihead),
    .itail       (itail),
    .ivch_0      (ivch[0]),
    .ivch_1      (ivch[1]),
    .ivch_2      (ivch[2]),
    .ivch_3      (ivch[3]),
    .ivch_4      (ivch[4]),
    .icredit     (icredit),
    .icredit_vch (icredit_vch),
    .sel         (sel),
    .ogrant      (ogrant),
    .olock_vch   (olock_vch),
    .ocred_err   (ocred_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input logic rn, input logic [4:0] rq, input logic [4:0] hd,
                      input logic [4:0] tl, input logic [4:0] vc,
                      input logic cr, input logic cvc);
    logic [4:0] gexp;
    int dec_v, winner, nerr, inc_ok, i;
    @(negedge clk);
    chk("sel", 32'(sel), m_locked != 0 ? (32'd1 << m_owner) : 32'd0);
    chk("olock_vch", 32'(olock_vch), 32'(m_lvc));
    chk("ocred_err", 32'(ocred_err), 32'(m_err));
    chk("credit0", 32'(dut.credit_q[0]), 32'(m_cr[0]));
    chk("credit1", 32'(dut.credit_q[1]), 32'(m_cr[1]));
    rst_n = rn; ireq = rq; ihead = hd; itail = tl; ivch = vc;
    icredit = cr; icredit_vch = cvc;
    #1;
    gexp = (m_locked != 0 && rq[m_owner] && m_cr[m_lvc] > 0) ? 5'(1 << m_owner) : 5'd0;
    chk("ogrant", 32'(ogrant), 32'(gexp));
    @(posedge clk);
    if (!rn) begin
      m_locked = 0; m_owner = 0; m_lvc = 0; m_rr = 4; m_err = 0;
      m_cr[0] = DEPTH; m_cr[1] = DEPTH;
    end else begin
      dec_v  = (gexp != 0) ? m_lvc : -1;
      nerr   = (cr && m_cr[cvc] == DEPTH && dec_v != int'(cvc)) ? 1 : 0;
      inc_ok = (cr && (m_cr[cvc] < DEPTH || dec_v == int'(cvc))) ? 1 : 0;
      winner = -1;
      if (m_locked == 0) begin
        for (int k = 1; k <= 5; k++) begin
          i = (m_rr + k) % 5;
          if (winner < 0 && rq[i] && hd[i] && m_cr[vc[i]] > 0) winner = i;
        end
      end
      if (dec_v >= 0) m_cr[dec_v]--;
      if (inc_ok != 0) m_cr[cvc]++;
      m_err = nerr;
      if (m_locked != 0 && gexp != 0 && tl[m_owner]) begin
        m_locked = 0; m_rr = m_owner;
      end else if (m_locked == 0 && winner >= 0) begin
        m_locked = 1; m_owner = winner; m_lvc = int'(vc[winner]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ireq = '0; ihead = '0; itail = '0; ivch = '0;
    icredit = 1'b0; icredit_vch = '0;
    repeat (3) @(posedge clk);

    // Inputs 0 and 2 single-flit packets on VC 0
    step(1, 5'b00101, 5'b00101, 5'b00101, 5'b00000, 0, 0);
    #1 chk("tp1_sel_n1", 32'(sel), 32'b00001);
    step(1, 5'b00101, 5'b00101, 5'b00101, 5'b00000, 0, 0);
    #1 chk("tp1_idle_n2", 32'(sel), 32'd0);
    step(1, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 0, 0);
    #1 chk("tp1_sel_n3", 32'(sel), 32'b00100);
    step(1, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 0, 0);
    #1 chk("tp1_cr0", 32'(dut.credit_q[0]), 32'd2);

    // Input 3 four-flit packet on VC 1 while input 1 waits
    step(1, 5'b01010, 5'b01010, 5'b00000, 5'b01000, 0, 0);
    for (int f = 0; f < 4; f++) begin
      #1 chk("tp2_sel_hold", 32'(sel), 32'b01000);
      step(1, 5'b01010, (f == 0) ? 5'b01010 : 5'b00010,
           (f == 3) ? 5'b01000 : 5'b00000, 5'b01000, 0, 0);
    end
    #1 chk("tp2_cr1", 32'(dut.credit_q[1]), 32'd0);
    step(1, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 0, 0);
    step(1, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 0, 0);

    // Credit starvation mid-packet on VC 0
    step(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1, 0);
    #1 chk("tp3_sel_held", 32'(sel), 32'b00001);
    step(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 0, 0);

    // Refill VC 0, then overflow it once
    for (int n = 0; n < DEPTH; n++) begin
      if (m_cr[0] < DEPTH) step(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 0);
    end
    step(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 0);
    #1 chk("tp5_err_pulse", 32'(ocred_err), 32'd1);
    step(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0);
    #1 chk("tp5_err_clear", 32'(ocred_err), 32'd0);
    chk("tp5_cr0", 32'(dut.credit_q[0]), 32'd4);

    // Grant and credit return on VC 0 in the same cycle at count 2
    step(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1, 0);
    #1 chk("tp4_cr0_same", 32'(dut.credit_q[0]), 32'd2);
    step(1, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 0, 0);

    // Reset in the middle of a packet from input 2
    step(1, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 0, 0);
    step(1, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 0, 0);
    step(0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 0, 0);
    #1 chk("tp6_sel_rst", 32'(sel), 32'd0);
    chk("tp6_cr_rst", 32'({dut.credit_q[1], dut.credit_q[0]}), 32'({3'd4, 3'd4}));
    step(1, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 0, 0);
    #1 chk("tp6_sel_in4", 32'(sel), 32'b10000);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      logic       rn, cr, cvc;
      logic [4:0] rq, hd, tl, vc;
      rn  = ($urandom_range(0, 249) != 0);
      rq  = 5'($urandom);
      hd  = 5'($urandom) & 5'($urandom);
      tl  = 5'($urandom) & 5'($urandom);
      vc  = 5'($urandom);
      cr  = ($urandom_range(0, 2) == 0);
      cvc = 1'($urandom);
      step(rn, rq, hd, tl, vc, cr, cvc);
    end
    step(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
